// File: rtl/health_manager_if.sv
// Player-state / health bundle between the game controller side and the
// health manager. The controller side (master) drives the round state,
// the player states and the positions. The health manager (slave) returns
// the healths and the per-player event flags.
interface health_manager_if;
   logic [2:0] game_state;
   logic [2:0] player1_state;
   logic [2:0] player2_state;
   logic [9:0] player1_x;
   logic [9:0] player2_x;
   logic [2:0] player1_health;
   logic [2:0] player2_health;
   logic       p1_hit;
   logic       p2_hit;
   logic       p1_blocked;
   logic       p2_blocked;
   logic       p1_invuln;
   logic       p2_invuln;

   modport master (
      output game_state, player1_state, player2_state, player1_x, player2_x,
      input  player1_health, player2_health, p1_hit, p2_hit,
             p1_blocked, p2_blocked, p1_invuln, p2_invuln
   );

   modport slave (
      input  game_state, player1_state, player2_state, player1_x, player2_x,
      output player1_health, player2_health, p1_hit, p2_hit,
             p1_blocked, p2_blocked, p1_invuln, p2_invuln
   );
endinterface

// File: rtl/health_manager.sv
// Per-frame hit resolution for a two-player fighting round.
// A strike resolves when the attacker is ATK_ACTIVE, its latch is clear,
// the players are in contact, and the defender is vulnerable and still alive.
// A blocking defender only produces a blocked pulse. Any other defender loses
// one point and becomes immune for INVULN_FRAMES frames. IDLE and COUNTDOWN
// reload the round. Game states 3..7 freeze health while the immunity
// timers run down.
module health_manager #(
   parameter logic [2:0] MAX_HEALTH    = 3'd5,
   parameter logic [9:0] RANGE         = 10'd40,
   parameter logic [5:0] INVULN_FRAMES = 6'd30
) (
   input  logic             clk,
   input  logic             reset,
   health_manager_if.slave  hm
);

   localparam logic [2:0] GS_COUNTDOWN  = 3'd1;
   localparam logic [2:0] GS_FIGHT      = 3'd2;
   localparam logic [2:0] ST_ATK_ACTIVE = 3'd4;
   localparam logic [2:0] ST_BLOCK      = 3'd6;

   // Absolute horizontal distance. Taking the larger minus the smaller
   // keeps the result in range, so it never wraps.
   function automatic logic [9:0] abs_dist(input logic [9:0] a, input logic [9:0] b);
      logic [9:0] d;
      if (a >= b) begin
         d = a - b;
      end else begin
         d = b - a;
      end
      return d;
   endfunction

   // Frame counter decrement that stops at zero.
   function automatic logic [5:0] dec_sat6(input logic [5:0] v);
      logic [5:0] r;
      if (v != 6'd0) begin
         r = v - 6'd1;
      end else begin
         r = 6'd0;
      end
      return r;
   endfunction

   // Health decrement that stops at zero.
   function automatic logic [2:0] dec_sat3(input logic [2:0] v);
      logic [2:0] r;
      if (v != 3'd0) begin
         r = v - 3'd1;
      end else begin
         r = 3'd0;
      end
      return r;
   endfunction

   logic [2:0] p1_health_r, p2_health_r;
   logic [5:0] p1_cnt_r,    p2_cnt_r;
   logic       p1_latch_r,  p2_latch_r;
   logic       p1_hit_r,    p2_hit_r;
   logic       p1_blk_r,    p2_blk_r;

   logic [2:0] p1_health_s, p2_health_s;
   logic [5:0] p1_cnt_s,    p2_cnt_s;
   logic       p1_latch_s,  p2_latch_s;
   logic       p1_hit_s,    p2_hit_s;
   logic       p1_blk_s,    p2_blk_s;

   logic       reload_s;
   logic       fight_s;
   logic       contact_s;
   logic       p1_strike_s;   // P1 lands or is blocked on P2 this frame
   logic       p2_strike_s;   // P2 lands or is blocked on P1 this frame

   assign reload_s  = (hm.game_state <= GS_COUNTDOWN);
   assign fight_s   = (hm.game_state == GS_FIGHT);
   assign contact_s = (abs_dist(hm.player1_x, hm.player2_x) <= RANGE);

   assign p1_strike_s = fight_s && (hm.player1_state == ST_ATK_ACTIVE) && !p1_latch_r &&
                        contact_s && (p2_cnt_r == 6'd0) && (p2_health_r != 3'd0);
   assign p2_strike_s = fight_s && (hm.player2_state == ST_ATK_ACTIVE) && !p2_latch_r &&
                        contact_s && (p1_cnt_r == 6'd0) && (p1_health_r != 3'd0);

   // Next-state for health, immunity timers, attack latches and event pulses.
   always_comb begin
      p1_health_s = p1_health_r;
      p2_health_s = p2_health_r;
      p1_cnt_s    = p1_cnt_r;
      p2_cnt_s    = p2_cnt_r;
      p1_latch_s  = p1_latch_r;
      p2_latch_s  = p2_latch_r;
      p1_hit_s    = 1'b0;
      p2_hit_s    = 1'b0;
      p1_blk_s    = 1'b0;
      p2_blk_s    = 1'b0;
      if (reload_s) begin
         // Reload beats any strike resolved on the same frame.
         p1_health_s = MAX_HEALTH;
         p2_health_s = MAX_HEALTH;
         p1_cnt_s    = 6'd0;
         p2_cnt_s    = 6'd0;
         p1_latch_s  = 1'b0;
         p2_latch_s  = 1'b0;
      end else begin
         // Strikes only happen in FIGHT. Outside FIGHT both strike terms
         // are zero, so this branch just runs the timers down.
         p2_hit_s = p1_strike_s && (hm.player2_state != ST_BLOCK);
         p2_blk_s = p1_strike_s && (hm.player2_state == ST_BLOCK);
         p1_hit_s = p2_strike_s && (hm.player1_state != ST_BLOCK);
         p1_blk_s = p2_strike_s && (hm.player1_state == ST_BLOCK);

         if (p1_hit_s) begin
            p1_health_s = dec_sat3(p1_health_r);
            p1_cnt_s    = INVULN_FRAMES;
         end else begin
            p1_cnt_s    = dec_sat6(p1_cnt_r);
         end
         if (p2_hit_s) begin
            p2_health_s = dec_sat3(p2_health_r);
            p2_cnt_s    = INVULN_FRAMES;
         end else begin
            p2_cnt_s    = dec_sat6(p2_cnt_r);
         end

         // A latch lives only for one ATK_ACTIVE run of its attacker.
         if (hm.player1_state == ST_ATK_ACTIVE) begin
            p1_latch_s = p1_latch_r | p1_strike_s;
         end else begin
            p1_latch_s = 1'b0;
         end
         if (hm.player2_state == ST_ATK_ACTIVE) begin
            p2_latch_s = p2_latch_r | p2_strike_s;
         end else begin
            p2_latch_s = 1'b0;
         end
      end
   end

   // Frame-edge state update. Reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         p1_health_r <= MAX_HEALTH;
         p2_health_r <= MAX_HEALTH;
         p1_cnt_r    <= 6'd0;
         p2_cnt_r    <= 6'd0;
         p1_latch_r  <= 1'b0;
         p2_latch_r  <= 1'b0;
         p1_hit_r    <= 1'b0;
         p2_hit_r    <= 1'b0;
         p1_blk_r    <= 1'b0;
         p2_blk_r    <= 1'b0;
      end else begin
         p1_health_r <= p1_health_s;
         p2_health_r <= p2_health_s;
         p1_cnt_r    <= p1_cnt_s;
         p2_cnt_r    <= p2_cnt_s;
         p1_latch_r  <= p1_latch_s;
         p2_latch_r  <= p2_latch_s;
         p1_hit_r    <= p1_hit_s;
         p2_hit_r    <= p2_hit_s;
         p1_blk_r    <= p1_blk_s;
         p2_blk_r    <= p2_blk_s;
      end
   end

   assign hm.player1_health = p1_health_r;
   assign hm.player2_health = p2_health_r;
   assign hm.p1_hit         = p1_hit_r;
   assign hm.p2_hit         = p2_hit_r;
   assign hm.p1_blocked     = p1_blk_r;
   assign hm.p2_blocked     = p2_blk_r;
   assign hm.p1_invuln      = (p1_cnt_r != 6'd0);
   assign hm.p2_invuln      = (p2_cnt_r != 6'd0);

endmodule

// File: tb/tb_health_manager.sv
// Scoreboard bench for health_manager. Each frame the bench drives inputs,
// advances its own reference model and queues the expected outputs. After
// the clock edge it pops the queued entry and compares it with the DUT.
// Directed checks after each scenario pin the key results to hand-derived
// constants.
module tb_health_manager;

   logic clk;
   logic reset;

   health_manager_if hm_if();

   health_manager dut (
      .clk   (clk),
      .reset (reset),
      .hm    (hm_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int h1;
      int h2;
      int hit1;
      int hit2;
      int blk1;
      int blk2;
      int inv1;
      int inv2;
   } exp_t;

   exp_t sb_q[$];

   int n_checks;
   int n_fail;

   // Reference model state.
   int m_h1, m_h2, m_c1, m_c2;
   int m_l1, m_l2;

   // Event tallies for the current scenario.
   int n_hit1, n_hit2, n_blk1, n_blk2, n_inv2;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_counts();
      n_hit1 = 0; n_hit2 = 0; n_blk1 = 0; n_blk2 = 0; n_inv2 = 0;
   endtask

   // One frame: drive inputs, advance the model, queue the expected result,
   // clock once, then pop the queue and compare.
   task automatic step(input logic rst, input logic [2:0] gs, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [9:0] x1, input logic [9:0] x2);
      int d;
      bit fight, st1, st2, hit1, hit2, blk1, blk2;
      exp_t e, o;
      reset                = rst;
      hm_if.game_state     = gs;
      hm_if.player1_state  = s1;
      hm_if.player2_state  = s2;
      hm_if.player1_x      = x1;
      hm_if.player2_x      = x2;
      hit1 = 0; hit2 = 0; blk1 = 0; blk2 = 0;
      if (rst || gs < 3'd2) begin
         m_h1 = 5; m_h2 = 5; m_c1 = 0; m_c2 = 0; m_l1 = 0; m_l2 = 0;
      end else begin
         fight = (gs == 3'd2);
         d = (x1 >= x2) ? int'(x1) - int'(x2) : int'(x2) - int'(x1);
         st1 = fight && s1 == 3'd4 && m_l1 == 0 && d <= 40 && m_c2 == 0 && m_h2 != 0;
         st2 = fight && s2 == 3'd4 && m_l2 == 0 && d <= 40 && m_c1 == 0 && m_h1 != 0;
         hit2 = st1 && s2 != 3'd6;
         blk2 = st1 && s2 == 3'd6;
         hit1 = st2 && s1 != 3'd6;
         blk1 = st2 && s1 == 3'd6;
         m_c1 = hit1 ? 30 : (m_c1 > 0 ? m_c1 - 1 : 0);
         m_c2 = hit2 ? 30 : (m_c2 > 0 ? m_c2 - 1 : 0);
         if (hit1 && m_h1 > 0) m_h1--;
         if (hit2 && m_h2 > 0) m_h2--;
         m_l1 = (s1 == 3'd4) ? int'(m_l1 != 0 || st1) : 0;
         m_l2 = (s2 == 3'd4) ? int'(m_l2 != 0 || st2) : 0;
      end
      e.h1 = m_h1; e.h2 = m_h2;
      e.hit1 = hit1; e.hit2 = hit2; e.blk1 = blk1; e.blk2 = blk2;
      e.inv1 = (m_c1 > 0); e.inv2 = (m_c2 > 0);
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      o = sb_q.pop_front();
      check_eq("h1",   int'(hm_if.player1_health), o.h1);
      check_eq("h2",   int'(hm_if.player2_health), o.h2);
      check_eq("hit1", int'(hm_if.p1_hit),         o.hit1);
      check_eq("hit2", int'(hm_if.p2_hit),         o.hit2);
      check_eq("blk1", int'(hm_if.p1_blocked),     o.blk1);
      check_eq("blk2", int'(hm_if.p2_blocked),     o.blk2);
      check_eq("inv1", int'(hm_if.p1_invuln),      o.inv1);
      check_eq("inv2", int'(hm_if.p2_invuln),      o.inv2);
      n_hit1 += int'(hm_if.p1_hit);
      n_hit2 += int'(hm_if.p2_hit);
      n_blk1 += int'(hm_if.p1_blocked);
      n_blk2 += int'(hm_if.p2_blocked);
      n_inv2 += int'(hm_if.p2_invuln);
   endtask

   task automatic run(input int n, input logic [2:0] gs, input logic [2:0] s1,
                      input logic [2:0] s2, input logic [9:0] x1, input logic [9:0] x2);
      for (int i = 0; i < n; i++) step(1'b0, gs, s1, s2, x1, x2);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      m_h1 = 5; m_h2 = 5; m_c1 = 0; m_c2 = 0; m_l1 = 0; m_l2 = 0;
      clear_counts();

      // Reset for two frames.
      step(1'b1, 3'd0, 3'd0, 3'd0, 10'd100, 10'd130);
      step(1'b1, 3'd0, 3'd0, 3'd0, 10'd100, 10'd130);
      check_eq("rst_h1", int'(hm_if.player1_health), 5);
      check_eq("rst_h2", int'(hm_if.player2_health), 5);
      check_eq("rst_inv", int'(hm_if.p1_invuln) + int'(hm_if.p2_invuln), 0);
      check_eq("rst_pulse", int'(hm_if.p1_hit) + int'(hm_if.p2_hit) +
               int'(hm_if.p1_blocked) + int'(hm_if.p2_blocked), 0);

      // Single hit at distance 30 with the attack held for 10 frames.
      clear_counts();
      run(2, 3'd2, 3'd0, 3'd0, 10'd100, 10'd130);
      run(10, 3'd2, 3'd4, 3'd0, 10'd100, 10'd130);
      check_eq("single_hits", n_hit2, 1);
      check_eq("single_h2", int'(hm_if.player2_health), 4);
      run(40, 3'd2, 3'd0, 3'd0, 10'd100, 10'd130);
      check_eq("single_inv_frames", n_inv2, 30);
      check_eq("single_hits_total", n_hit2, 1);

      // Distance 41 in either order: no contact.
      run(1, 3'd0, 3'd0, 3'd0, 10'd100, 10'd130);
      clear_counts();
      run(20, 3'd2, 3'd4, 3'd0, 10'd100, 10'd141);
      run(1, 3'd2, 3'd0, 3'd0, 10'd141, 10'd100);
      run(20, 3'd2, 3'd4, 3'd0, 10'd141, 10'd100);
      check_eq("range_hits", n_hit2, 0);
      check_eq("range_h2", int'(hm_if.player2_health), 5);

      // Distance exactly 40 with the defender blocking.
      clear_counts();
      run(1, 3'd2, 3'd0, 3'd6, 10'd100, 10'd140);
      run(10, 3'd2, 3'd4, 3'd6, 10'd100, 10'd140);
      check_eq("block_pulses", n_blk2, 1);
      check_eq("block_hits", n_hit2, 0);
      check_eq("block_inv", n_inv2, 0);
      check_eq("block_h2", int'(hm_if.player2_health), 5);

      // One ATK_ACTIVE run of 100 frames lands only once.
      run(1, 3'd2, 3'd0, 3'd0, 10'd100, 10'd140);
      clear_counts();
      run(100, 3'd2, 3'd4, 3'd0, 10'd100, 10'd140);
      check_eq("latch_hits", n_hit2, 1);
      check_eq("latch_h2", int'(hm_if.player2_health), 4);

      // Re-entering ATK_ACTIVE during immunity lands at edge N+31.
      run(1, 3'd0, 3'd0, 3'd0, 10'd100, 10'd130);
      clear_counts();
      run(1, 3'd2, 3'd4, 3'd0, 10'd100, 10'd130);   // edge N
      run(5, 3'd2, 3'd0, 3'd0, 10'd100, 10'd130);   // edges N+1..N+5
      run(25, 3'd2, 3'd4, 3'd0, 10'd100, 10'd130);  // edges N+6..N+30
      check_eq("rehit_blocked_by_inv", n_hit2, 1);
      run(1, 3'd2, 3'd4, 3'd0, 10'd100, 10'd130);   // edge N+31
      check_eq("rehit_lands", n_hit2, 2);
      check_eq("rehit_h2", int'(hm_if.player2_health), 3);
      run(40, 3'd2, 3'd4, 3'd0, 10'd100, 10'd130);
      check_eq("rehit_stays", int'(hm_if.player2_health), 3);
      check_eq("rehit_total", n_hit2, 2);

      // Reset while the defender is immune mid-round.
      run(1, 3'd2, 3'd0, 3'd0, 10'd100, 10'd130);
      run(1, 3'd2, 3'd4, 3'd0, 10'd100, 10'd130);
      step(1'b1, 3'd2, 3'd0, 3'd0, 10'd100, 10'd130);
      check_eq("rst_mid_inv", int'(hm_if.p2_invuln), 0);
      check_eq("rst_mid_h2", int'(hm_if.player2_health), 5);

      // Trades down to a draw.
      run(1, 3'd0, 3'd0, 3'd0, 10'd100, 10'd140);
      for (int k = 0; k < 4; k++) begin
         run(1, 3'd2, 3'd4, 3'd4, 10'd100, 10'd140);
         run(31, 3'd2, 3'd0, 3'd0, 10'd100, 10'd140);
      end
      check_eq("trade_h1_one", int'(hm_if.player1_health), 1);
      check_eq("trade_h2_one", int'(hm_if.player2_health), 1);
      clear_counts();
      run(1, 3'd2, 3'd4, 3'd4, 10'd100, 10'd140);
      check_eq("draw_hit1", n_hit1, 1);
      check_eq("draw_hit2", n_hit2, 1);
      check_eq("draw_h1", int'(hm_if.player1_health), 0);
      check_eq("draw_h2", int'(hm_if.player2_health), 0);
      run(31, 3'd2, 3'd0, 3'd0, 10'd100, 10'd140);
      clear_counts();
      run(5, 3'd2, 3'd4, 3'd4, 10'd100, 10'd140);
      check_eq("dead_pulses", n_hit1 + n_hit2 + n_blk1 + n_blk2, 0);

      // Round over at 2/0 holds, then IDLE reloads.
      run(1, 3'd0, 3'd0, 3'd0, 10'd100, 10'd130);
      for (int k = 0; k < 5; k++) begin
         run(1, 3'd2, 3'd4, 3'd0, 10'd100, 10'd130);
         run(31, 3'd2, 3'd0, 3'd0, 10'd100, 10'd130);
      end
      for (int k = 0; k < 3; k++) begin
         run(1, 3'd2, 3'd0, 3'd4, 10'd100, 10'd130);
         run(31, 3'd2, 3'd0, 3'd0, 10'd100, 10'd130);
      end
      clear_counts();
      run(10, 3'd3, 3'd4, 3'd4, 10'd100, 10'd130);
      check_eq("over_h1", int'(hm_if.player1_health), 2);
      check_eq("over_h2", int'(hm_if.player2_health), 0);
      check_eq("over_pulses", n_hit1 + n_hit2 + n_blk1 + n_blk2, 0);
      run(1, 3'd0, 3'd0, 3'd0, 10'd100, 10'd130);
      check_eq("reload_h1", int'(hm_if.player1_health), 5);
      check_eq("reload_h2", int'(hm_if.player2_health), 5);

      // A strike on the same edge as COUNTDOWN entry is overridden.
      run(1, 3'd2, 3'd4, 3'd0, 10'd100, 10'd130);
      run(31, 3'd2, 3'd0, 3'd0, 10'd100, 10'd130);
      check_eq("cd_pre_h2", int'(hm_if.player2_health), 4);
      clear_counts();
      run(1, 3'd1, 3'd4, 3'd0, 10'd100, 10'd130);
      check_eq("cd_h2", int'(hm_if.player2_health), 5);
      check_eq("cd_pulse", n_hit2, 0);

      check_eq("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/health_manager.md
# health_manager

Tracks both players' health during a round and feeds `player1_health`/`player2_health` to the game controller. Each 60 Hz frame it evaluates attack contact from the player state codes and horizontal positions, applies one point of damage per landed hit, and enforces a post-hit invulnerability window. It reloads full health whenever the game controller is idle or counting down, and freezes once the round is decided.

## Interface
- `MAX_HEALTH`, default 3'd5: health loaded on reset, in IDLE and in COUNTDOWN (1..7).
- `RANGE`, default 10'd40: maximum `|player1_x - player2_x|` for contact.
- `INVULN_FRAMES`, default 6'd30: number of frames a defender is immune after taking a hit (1..63).

Ports:
- `clk` input 1: 60 Hz frame clock.
- `reset` input 1: synchronous, active-high.
- `game_state` input 3: 0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3/4/5 round over.
- `player1_state`, `player2_state` input 3 each:
  - 0 IDLE, 1 FWD, 2 BACK, 3 ATK_START, 4 ATK_ACTIVE, 5 ATK_RECOVER, 6 BLOCK, 7 HITSTUN.
- `player1_x`, `player2_x` input 10 each: horizontal pixel position, unsigned.
- `player1_health`, `player2_health` output 3 each: registered health.
- `p1_hit`, `p2_hit` output 1 each: one-cycle pulse when that player loses health.
- `p1_blocked`, `p2_blocked` output 1 each: one-cycle pulse when that player blocks a hit.
- `p1_invuln`, `p2_invuln` output 1 each: high while that player's invulnerability counter is nonzero.

## Operation
- Reset: both healths = `MAX_HEALTH`; all pulses 0; invulnerability counters 0; attack latches clear.
- Modes, decided from `game_state`:
  - IDLE/COUNTDOWN (0, 1): reload both healths to `MAX_HEALTH`, clear counters and latches, no pulses.
  - FIGHT (2): hit evaluation active.
  - 3–7: hold healths; counters keep decrementing to 0; no new hits.
- Contact means `dist <= RANGE`, with `dist = (x1 >= x2) ? x1 - x2 : x2 - x1`. This is 10-bit unsigned and never wraps.
- Attack latch per attacker:
  - Set when that attacker's strike is resolved as a hit or a block.
  - Cleared whenever the attacker's state is not ATK_ACTIVE.
  - One ATK_ACTIVE run resolves at most one strike.
- A strike by P1 on P2 is resolved in a FIGHT cycle when all of these hold:
  - `player1_state` == ATK_ACTIVE;
  - P1's latch is clear;
  - contact;
  - `p2_invuln` == 0;
  - `player2_health` != 0.
- Resolution of that strike:
  - If `player2_state` == BLOCK: pulse `p2_blocked`; health unchanged; no invulnerability.
  - Otherwise: `player2_health` decrements by 1, saturating at 0; pulse `p2_hit`; load P2's counter with `INVULN_FRAMES`.
  - In both cases, set P1's latch.
- Strikes against an invulnerable or 0-health defender are not resolved and do not set the latch. The strike can still land later in the same ATK_ACTIVE run once the defender becomes vulnerable.
- P2 strikes on P1 are symmetric.
- Simultaneous strikes (trade): both players resolve in the same cycle independently, so both can take damage. Both reaching 0 in the same cycle yields game EQ.
- Invulnerability counters decrement by 1 per cycle while nonzero, in every mode except IDLE/COUNTDOWN (where they are cleared).

## Timing
- Inputs are sampled at the rising `clk` edge. Resolution is combinational from the current inputs and registered state.
- Health, pulses, counters and latches update at that same edge and are visible the following cycle: one-cycle latency from ATK_ACTIVE+contact to the health change.
- `p1_hit`/`p2_hit`/`p1_blocked`/`p2_blocked` are high for exactly one cycle per resolved strike.
- After a hit at edge N, the defender is immune for edges N+1 .. N+`INVULN_FRAMES`. The earliest next hit lands at edge N+`INVULN_FRAMES`+1.
- `reset` takes priority over everything, including mid-round and mid-invulnerability.
- A `game_state` change to IDLE/COUNTDOWN on the same edge as a strike means the reload wins.

## Test plan
- Reset: assert `reset` for 2 cycles -> health 5/5, all pulses 0, `p1_invuln`=`p2_invuln`=0.
- Single hit: FIGHT, x1=100, x2=130, P1 ATK_ACTIVE for 10 cycles -> `player2_health` 5→4 one cycle later, one `p2_hit` pulse, `p2_invuln` high for exactly 30 cycles.
- Out of range / blocked / latch:
  - x2=141 (dist 41) -> no change.
  - dist 40 with P2 in BLOCK -> one `p2_blocked` pulse, health 5.
  - ATK_ACTIVE held 100 cycles -> exactly one hit.
- Invulnerability re-hit: P1 leaves ATK_ACTIVE, then re-enters it while `p2_invuln` is still high and stays active -> the second hit lands at edge N+31, health 3, then stays 3.
- Trade to draw: both healths at 1, both ATK_ACTIVE in range in the same cycle -> both 0 next cycle, both hit pulses; further strikes give no pulses.
- Reload: game_state 3 with health 2/0 -> held; then game_state 0 -> 5/5 next cycle. A strike on the same edge as the COUNTDOWN entry is ignored.
